timed_decoder: RTL

TIMED_DECODER -- requirements
Module: timed_decoder

---
 rtl/timed_decoder_pkg.sv | 20 ++
 rtl/timed_decoder_onehot_dec.sv | 15 +
 rtl/timed_decoder.sv | 87 ++++++++
 3 files changed

// File: rtl/timed_decoder_pkg.sv
// Shared types and constants for the timed one-hot enable decoder.
package timed_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    PULSE = 2'd2
  } state_t;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_PULSE = 1'b1;

  // Counter width for a pulse of len cycles; never narrower than one bit.
  function automatic int cnt_width(input int len);
    int w;
    w = $clog2(len + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/timed_decoder_onehot_dec.sv
// Combinational address-to-one-hot map; all-zero when address >= NUM_OUT.
module onehot_dec #(
  parameter int ADDR_W  = 2,
  parameter int NUM_OUT = 4
) (
  input  logic [ADDR_W-1:0]  address,
  output logic [0:NUM_OUT-1] onehot
);

  // NUM_OUT <= 2**ADDR_W, so every index fits in ADDR_W bits.
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
    assign onehot[i] = (address == ADDR_W'(i));
  end

endmodule

// File: rtl/timed_decoder.sv
// One-hot enable decoder with level (hold) and timed pulse modes, sticky
// out-of-range error, and synchronous clear.
module timed_decoder
  import timed_decoder_pkg::*;
#(
  parameter int ADDR_W    = 2,
  parameter int NUM_OUT   = 4,
  parameter int PULSE_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] address,
  input  logic              mode,
  input  logic              clear,
  output logic [0:NUM_OUT-1] en,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = cnt_width(PULSE_LEN);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [0:NUM_OUT-1] sel;
  logic               in_range;
  logic               accept;

  onehot_dec #(
    .ADDR_W  (ADDR_W),
    .NUM_OUT (NUM_OUT)
  ) u_dec (
    .address (address),
    .onehot  (sel)
  );

  assign in_range = |sel;
  assign in_ready = reset && (state != PULSE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      en    <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else if (clear) begin
      // Clear wins over a simultaneous accept and aborts any pulse.
      state <= IDLE;
      cnt   <= '0;
      en    <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else if (accept) begin
      if (!in_range) begin
        state <= IDLE;
        cnt   <= '0;
        en    <= '0;
        busy  <= 1'b0;
        err   <= 1'b1;
      end else if (mode == MODE_PULSE) begin
        state <= PULSE;
        cnt   <= CNT_LOAD;
        en    <= sel;
        busy  <= 1'b1;
      end else begin
        state <= HOLD;
        cnt   <= '0;
        en    <= sel;
        busy  <= 1'b0;
      end
    end else if (state == PULSE) begin
      // Counter reads PULSE_LEN-1 on the first pulse cycle, exit when it reads 0.
      if (cnt == '0) begin
        state <= IDLE;
        en    <= '0;
        busy  <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule
